sipo_deser: RTL and testbench

Serial-in/parallel-out deserializer. It consumes the single-bit registered stream produced by the set/reset D flip-flop stage and assembles WIDTH-bit words. Each completed word is presented on a valid/ready output holding register to the next stage. It sits directly downstream of the flip-flop stage, with one bit per qualified clock.

---
 rtl/sipo_bit_counter.sv | 42 ++++
 rtl/sipo_deser.sv | 97 +++++++++
 tb/tb_sipo_deser.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/sipo_bit_counter.sv
// Modulo-WIDTH bit counter for the deserializer.
// Terminal count flags the bit that completes a word (last count with enable high).
module sipo_bit_counter #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_clr,
   input  logic             i_en,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_tc
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear wins, otherwise advance and wrap on enable.
   always_comb begin
      cnt_d = cnt_q;
      if (i_clr) begin
         cnt_d = '0;
      end else if (i_en) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_cnt = cnt_q;
   assign o_tc  = (cnt_q == LAST) & i_en;

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer with a valid/ready holding register.
// Assembles WIDTH-bit words from a qualified bit stream; overwriting an
// unconsumed word raises a sticky overrun flag.
module sipo_deser #(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 1,
   localparam int CNT_W    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_clr,
   input  logic             i_sdata,
   input  logic             i_svalid,
   input  logic             i_pready,
   output logic [WIDTH-1:0] o_pdata,
   output logic             o_pvalid,
   output logic [CNT_W-1:0] o_bit_cnt,
   output logic             o_overrun
);

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [WIDTH-1:0] pdata_q, pdata_d;
   logic             overrun_q, overrun_d;
   logic             word_done;

   sipo_bit_counter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_bit_counter (
      .clk     (clk),
      .reset_n (reset_n),
      .i_clr   (i_clr),
      .i_en    (i_svalid),
      .o_cnt   (o_bit_cnt),
      .o_tc    (word_done)
   );

   // Next-state: shift, load completed word, output handshake, overrun, clear.
   always_comb begin
      sh_d      = sh_q;
      pdata_d   = pdata_q;
      state_d   = state_q;
      overrun_d = overrun_q;

      if (i_svalid) begin
         if (MSB_FIRST != 0) begin
            sh_d = {sh_q[WIDTH-2:0], i_sdata};
         end else begin
            sh_d = {i_sdata, sh_q[WIDTH-1:1]};
         end
      end

      // The completing word includes this cycle's bit, so load from sh_d.
      if (word_done) begin
         pdata_d = sh_d;
         state_d = S_FULL;
         if ((state_q == S_FULL) && !i_pready) begin
            overrun_d = 1'b1;
         end
      end else if ((state_q == S_FULL) && i_pready) begin
         state_d = S_EMPTY;
      end

      if (i_clr) begin
         sh_d      = '0;
         pdata_d   = '0;
         state_d   = S_EMPTY;
         overrun_d = 1'b0;
      end
   end

   // Datapath and output FSM registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sh_q      <= '0;
         pdata_q   <= '0;
         state_q   <= S_EMPTY;
         overrun_q <= 1'b0;
      end else begin
         sh_q      <= sh_d;
         pdata_q   <= pdata_d;
         state_q   <= state_d;
         overrun_q <= overrun_d;
      end
   end

   assign o_pdata   = pdata_q;
   assign o_pvalid  = (state_q == S_FULL);
   assign o_overrun = overrun_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench for sipo_deser: an MSB-first and an LSB-first instance share
// the same stimulus; table rows check every cycle, hand sequences cover
// overrun, same-edge transfer/completion, async reset and sync clear.
module tb_sipo_deser;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       i_clr, i_sdata, i_svalid, i_pready;
   logic [7:0] pdata_m, pdata_l;
   logic       pvalid_m, pvalid_l, ovr_m, ovr_l;
   logic [2:0] cnt_m, cnt_l;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sipo_deser #(.WIDTH(8), .MSB_FIRST(1)) dut_m (
      .clk(clk), .reset_n(reset_n), .i_clr(i_clr), .i_sdata(i_sdata),
      .i_svalid(i_svalid), .i_pready(i_pready), .o_pdata(pdata_m),
      .o_pvalid(pvalid_m), .o_bit_cnt(cnt_m), .o_overrun(ovr_m));

   sipo_deser #(.WIDTH(8), .MSB_FIRST(0)) dut_l (
      .clk(clk), .reset_n(reset_n), .i_clr(i_clr), .i_sdata(i_sdata),
      .i_svalid(i_svalid), .i_pready(i_pready), .o_pdata(pdata_l),
      .o_pvalid(pvalid_l), .o_bit_cnt(cnt_l), .o_overrun(ovr_l));

   typedef struct {
      logic       sv, sd, pr;
      logic [7:0] em, el;
      logic       pv;
      logic [2:0] cnt;
      logic       ov;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic sv, sd, pr, input logic [7:0] em, el,
                      input logic pv, input logic [2:0] cnt, input logic ov);
      vec_t v;
      v.sv = sv; v.sd = sd; v.pr = pr; v.em = em; v.el = el;
      v.pv = pv; v.cnt = cnt; v.ov = ov;
      vecs.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input logic [7:0] em, el,
                          input logic pv, input logic [2:0] cnt, input logic ov);
      chk({tag, " pdata_m"}, 32'(pdata_m), 32'(em));
      chk({tag, " pdata_l"}, 32'(pdata_l), 32'(el));
      chk({tag, " pvalid_m"}, 32'(pvalid_m), 32'(pv));
      chk({tag, " pvalid_l"}, 32'(pvalid_l), 32'(pv));
      chk({tag, " cnt_m"}, 32'(cnt_m), 32'(cnt));
      chk({tag, " cnt_l"}, 32'(cnt_l), 32'(cnt));
      chk({tag, " ovr_m"}, 32'(ovr_m), 32'(ov));
      chk({tag, " ovr_l"}, 32'(ovr_l), 32'(ov));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] rev8(input logic [7:0] w);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = w[7-i];
      return r;
   endfunction

   // Sends w MSB-first; i_pready is applied only on the final bit's edge.
   task automatic send_word(input logic [7:0] w, input logic pr_last);
      for (int i = 7; i >= 0; i--) begin
         i_svalid = 1'b1;
         i_sdata  = w[i];
         i_pready = (i == 0) ? pr_last : 1'b0;
         tick();
      end
      i_svalid = 1'b0;
      i_pready = 1'b0;
   endtask

   task automatic idle(input logic pr, input logic clr);
      i_svalid = 1'b0;
      i_pready = pr;
      i_clr    = clr;
      tick();
      i_pready = 1'b0;
      i_clr    = 1'b0;
   endtask

   initial begin
      reset_n  = 1'b0;
      i_clr    = 1'b0;
      i_sdata  = 1'b0;
      i_svalid = 1'b0;
      i_pready = 1'b0;

      // 0xA5 = 1,0,1,0,0,1,0,1 (palindrome, same word either bit order)
      add(1,1,0, 8'h00,8'h00, 0,3'd1,0);
      add(1,0,0, 8'h00,8'h00, 0,3'd2,0);
      add(1,1,0, 8'h00,8'h00, 0,3'd3,0);
      add(1,0,0, 8'h00,8'h00, 0,3'd4,0);
      add(1,0,0, 8'h00,8'h00, 0,3'd5,0);
      add(1,1,0, 8'h00,8'h00, 0,3'd6,0);
      add(1,0,0, 8'h00,8'h00, 0,3'd7,0);
      add(1,1,0, 8'hA5,8'hA5, 1,3'd0,0);
      add(0,0,1, 8'hA5,8'hA5, 0,3'd0,0);
      // 0x01 sent MSB-first: LSB-first instance sees 0x80
      for (int i = 1; i <= 7; i++) add(1,0,0, 8'hA5,8'hA5, 0,3'(i),0);
      add(1,1,0, 8'h01,8'h80, 1,3'd0,0);
      add(0,0,1, 8'h01,8'h80, 0,3'd0,0);
      // 0x3C with a 3-cycle gap after bit 4 (noise on sdata/pready during gap)
      add(1,0,0, 8'h01,8'h80, 0,3'd1,0);
      add(1,0,0, 8'h01,8'h80, 0,3'd2,0);
      add(1,1,0, 8'h01,8'h80, 0,3'd3,0);
      add(1,1,0, 8'h01,8'h80, 0,3'd4,0);
      add(0,1,1, 8'h01,8'h80, 0,3'd4,0);
      add(0,0,0, 8'h01,8'h80, 0,3'd4,0);
      add(0,1,1, 8'h01,8'h80, 0,3'd4,0);
      add(1,1,0, 8'h01,8'h80, 0,3'd5,0);
      add(1,1,0, 8'h01,8'h80, 0,3'd6,0);
      add(1,0,0, 8'h01,8'h80, 0,3'd7,0);
      add(1,0,0, 8'h3C,8'h3C, 1,3'd0,0);
      add(0,0,1, 8'h3C,8'h3C, 0,3'd0,0);

      #12;
      chk_all("reset", 8'h00, 8'h00, 0, 3'd0, 0);
      reset_n = 1'b1;

      foreach (vecs[k]) begin
         i_svalid = vecs[k].sv;
         i_sdata  = vecs[k].sd;
         i_pready = vecs[k].pr;
         tick();
         chk_all($sformatf("vec%0d", k), vecs[k].em, vecs[k].el,
                 vecs[k].pv, vecs[k].cnt, vecs[k].ov);
      end
      i_svalid = 1'b0;
      i_pready = 1'b0;

      // Overrun: 0x11 pending, 0x22 completes without ready
      send_word(8'h11, 1'b0);
      chk_all("pend11", 8'h11, rev8(8'h11), 1, 3'd0, 0);
      send_word(8'h22, 1'b0);
      chk_all("ovr22", 8'h22, rev8(8'h22), 1, 3'd0, 1);
      idle(1'b1, 1'b0);
      chk_all("ovr_sticky", 8'h22, rev8(8'h22), 0, 3'd0, 1);
      idle(1'b0, 1'b0);
      chk_all("ovr_hold", 8'h22, rev8(8'h22), 0, 3'd0, 1);
      idle(1'b0, 1'b1);
      chk_all("ovr_clr", 8'h00, 8'h00, 0, 3'd0, 0);

      // Transfer and completion on the same edge: no overrun
      send_word(8'h11, 1'b0);
      send_word(8'h77, 1'b1);
      chk_all("xfer77", 8'h77, rev8(8'h77), 1, 3'd0, 0);
      idle(1'b1, 1'b0);
      chk_all("drain77", 8'h77, rev8(8'h77), 0, 3'd0, 0);

      // Async reset mid-word with a pending word and overrun
      send_word(8'h5A, 1'b0);
      send_word(8'h5A, 1'b0);
      for (int i = 0; i < 5; i++) begin
         i_svalid = 1'b1; i_sdata = 1'b1; tick();
      end
      i_svalid = 1'b0;
      chk_all("pre_rst", 8'h5A, rev8(8'h5A), 1, 3'd5, 1);
      #3 reset_n = 1'b0;
      #1 chk_all("async_rst", 8'h00, 8'h00, 0, 3'd0, 0);
      #2 reset_n = 1'b1;
      send_word(8'hFF, 1'b0);
      chk_all("ff_after_rst", 8'hFF, 8'hFF, 1, 3'd0, 0);

      // Same via sync clear; svalid/pready on the clear edge are ignored
      send_word(8'h5A, 1'b0);
      for (int i = 0; i < 5; i++) begin
         i_svalid = 1'b1; i_sdata = 1'b0; tick();
      end
      chk_all("pre_clr", 8'h5A, rev8(8'h5A), 1, 3'd5, 1);
      i_svalid = 1'b1; i_sdata = 1'b1; i_pready = 1'b1; i_clr = 1'b1;
      tick();
      i_clr = 1'b0; i_svalid = 1'b0; i_pready = 1'b0;
      chk_all("sync_clr", 8'h00, 8'h00, 0, 3'd0, 0);
      send_word(8'hFF, 1'b0);
      chk_all("ff_after_clr", 8'hFF, 8'hFF, 1, 3'd0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
